ps2_rx_fifo: RTL

Parametrised PS/2 device-to-host receiver, oversampled on the system clock, with a buffered output.
- Synchronises the raw ps2_clk/ps2_data pins and detects falling edges of ps2_clk.
- Deframes start/data/parity/stop with a configurable width and parity mode.
- Pushes good words into a FIFO drained by a valid/ready interface.
- Sits between the keyboard pins and the 68k-side register/interrupt logic.

---
 rtl/ps2_rx_fifo.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
// PS/2 device-to-host receiver, oversampled on clk, with a show-ahead output FIFO.
//   clk, reset            : system clock, synchronous active-high reset
//   ps2_clk, ps2_data     : raw asynchronous PS/2 pins
//   rd_data, rd_valid     : FIFO head word / non-empty flag
//   rd_ready              : consumer pops the head when rd_valid && rd_ready
//   fifo_count            : words currently held (0..FIFO_DEPTH)
//   busy                  : deframer is mid-frame
//   parity_err, frame_err : one-cycle pulses for a bad parity / bad stop or timeout
//   overflow              : one-cycle pulse when a good word is dropped on a full FIFO
module ps2_rx_fifo #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned PARITY_MODE = 1,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 2000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = PTR_W + 1;
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic                   acc_q, acc_d;
  logic                   par_ok_q, par_ok_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overflow_q, overflow_d;
  logic [DATA_W-1:0]      mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;

  logic sync_clk, sync_data, strobe, push, pop, full, accept;

  // Bit 0 is the newest sample; the top bit is the fully synchronised value.
  assign sync_clk  = clk_sync_q[SYNC_STAGES-1];
  assign sync_data = data_sync_q[SYNC_STAGES-1];
  assign strobe    = clk_prev_q & ~sync_clk;

  always_comb begin
    clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_prev_d   = sync_clk;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    acc_d        = acc_q;
    par_ok_d     = par_ok_q;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    push         = 1'b0;
    tmo_d        = (state_q == IDLE || strobe) ? '0 : tmo_q + TMO_W'(1);

    // Timeout takes priority over a coincident strobe: the frame is already stale.
    if (state_q != IDLE && tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
    end else if (strobe) begin
      case (state_q)
        IDLE: begin
          if (!sync_data) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            acc_d     = 1'b0;
          end
        end
        DATA: begin
          shift_d[bit_cnt_q] = sync_data;
          acc_d              = acc_q ^ sync_data;
          bit_cnt_d          = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            if (PARITY_MODE == 0) begin
              state_d  = STOP;
              par_ok_d = 1'b1;
            end else begin
              state_d = PARITY;
            end
          end
        end
        PARITY: begin
          par_ok_d = (PARITY_MODE == 1) ? (acc_q ^ sync_data) : ~(acc_q ^ sync_data);
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!sync_data)    frame_err_d  = 1'b1;
          else if (par_ok_q) push         = 1'b1;
          else               parity_err_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A full FIFO still accepts a push when the head is popped on the same edge;
  // in that case wr_ptr == rd_ptr and the popped slot is overwritten.
  always_comb begin
    pop        = (count_q != '0) && rd_ready;
    full       = (count_q == CW'(FIFO_DEPTH));
    accept     = push && (!full || pop);
    overflow_d = push && full && !pop;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (accept) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q   <= '1;
      data_sync_q  <= '1;
      clk_prev_q   <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      acc_q        <= 1'b0;
      par_ok_q     <= 1'b0;
      tmo_q        <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      clk_prev_q   <= clk_prev_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      acc_q        <= acc_d;
      par_ok_q     <= par_ok_d;
      tmo_q        <= tmo_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign rd_data    = mem_q[rd_ptr_q];
  assign rd_valid   = (count_q != '0);
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE);
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule
